// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: segment bit
// positions, scan state encoding and the digit-index width helper.
package display_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } scan_state_e;

   function automatic int idx_w(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot counter, digit index and scan state. Exports next-state values so the
// top can register its outputs aligned with the counter they describe.
module display_scan_timer
   import display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int BLANK    = 16,
   localparam int IW      = idx_w(DIGITS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   output logic          running_o,
   output logic          run_next_o,
   output logic [IW-1:0] idx_next_o,
   output logic          wrap_o,
   output logic          blank_o,
   output logic          frame_done_o
);

   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
   localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          frame_done_q;
   logic          wrap;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wrap    = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  wrap  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_done_q <= wrap;
      end
   end

   assign running_o    = (state_q == RUN);
   assign run_next_o   = (state_d == RUN);
   assign idx_next_o   = idx_d;
   assign wrap_o       = wrap;
   // Blank reflects the slot position the outputs will show next cycle.
   assign blank_o      = (state_d != RUN) || (cnt_d < BLANK_C);
   assign frame_done_o = frame_done_q;

endmodule

// File: rtl/display_scan_mux.sv
// Multi-digit 7-segment scan driver: double-buffered patterns swapped at frame
// boundaries, blank gating and pin polarity on fully registered outputs.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 1000,
   parameter int BLANK          = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [8*DIGITS-1:0] seg_in,
   input  logic                load,
   output logic [7:0]          seg_out,
   output logic [DIGITS-1:0]   digit_en,
   output logic                frame_done,
   output logic                load_pending
);

   localparam int IW = idx_w(DIGITS);
   localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

   logic                   running, run_next, wrap, blank;
   logic [IW-1:0]          idx_next;
   logic [DIGITS-1:0][7:0] active_q, active_d, shadow_q, shadow_d;
   logic                   pending_q, pending_d;
   logic [7:0]             seg_q, seg_n;
   logic [DIGITS-1:0]      dig_q, dig_n;

   display_scan_timer #(
      .DIGITS  (DIGITS),
      .PRESCALE(PRESCALE),
      .BLANK   (BLANK)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .running_o   (running),
      .run_next_o  (run_next),
      .idx_next_o  (idx_next),
      .wrap_o      (wrap),
      .blank_o     (blank),
      .frame_done_o(frame_done)
   );

   // Leaving RUN and the frame wrap are both safe points to commit a pattern;
   // a load on that same edge is newer than the shadow and takes priority.
   always_comb begin
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (!running) begin
         if (load) active_d = seg_in;
      end else if (!enable || wrap) begin
         if (load)           active_d = seg_in;
         else if (pending_q) active_d = shadow_q;
         pending_d = 1'b0;
      end else if (load) begin
         shadow_d  = seg_in;
         pending_d = 1'b1;
      end
   end

   always_comb begin
      seg_n = '0;
      dig_n = '0;
      if (run_next && !blank) begin
         seg_n           = active_d[idx_next];
         dig_n[idx_next] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         seg_q     <= SEG_OFF;
         dig_q     <= DIG_OFF;
      end else begin
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         seg_q     <= seg_n ^ SEG_OFF;
         dig_q     <= dig_n ^ DIG_OFF;
      end
   end

   assign seg_out      = seg_q;
   assign digit_en     = dig_q;
   assign load_pending = pending_q;

endmodule
